scpu_ctrl: RTL and testbench

Multi-cycle control sequencer for the 8-bit single-issue CPU.
- Fetches instructions from a 16-entry instruction memory over a req/ack handshake.
- Holds each instruction in an instruction register that drives the instruction decoder.
- Steps every instruction through DECODE, EXEC and WB, driving the register-file write enable, ALU controls and PC.
- Sits between instruction memory, the decoder, the register file and the ALU.

---
 rtl/scpu_ctrl.sv | 175 +++++++++++++++++
 tb/tb_scpu_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scpu_ctrl.sv
// scpu_ctrl: multi-cycle control sequencer for the 8-bit single-issue CPU.
// Fetches an instruction over imem req/ack, holds it in ir for the external
// decoder, then steps it through DECODE, EXEC and WB. All control outputs are
// registered, so nothing combinational runs from an input to an output.
//
// state  | meaning
// IDLE   | parked; leaves for FETCH when run=1
// FETCH  | imem_req high at imem_addr=pc until imem_ack
// DECODE | ir stable, decoder outputs settle
// EXEC   | ALU ops drive the ALU; JMP updates pc and retires here
// WB     | rf_we pulse, pc+1, retire
// HALT   | JMP-to-self reached; only reset leaves
module scpu_ctrl #(
  parameter logic [3:0] RESET_PC = 4'h0,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [3:0]       imem_addr,
  input  logic [7:0]       imem_rdata,
  input  logic             imem_ack,
  output logic [7:0]       ir,
  input  logic [1:0]       dec_opcode,
  input  logic [3:0]       dec_addr,
  output logic             alu_en,
  output logic [1:0]       alu_op,
  output logic             alu_sel_imm,
  output logic             rf_we,
  output logic [3:0]       pc,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_LI  = 2'b11;

  state_t           state_q, state_d;
  logic [3:0]       pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halted_q, halted_d;
  logic             imem_req_q, imem_req_d;
  logic             alu_en_q, alu_en_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             alu_sel_imm_q, alu_sel_imm_d;
  logic             rf_we_q, rf_we_d;

  // Next-state, pc, ir, retire and halt bookkeeping.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_opcode == OP_JMP) begin
          retired_d = retired_q + CNT_W'(1);
          if (dec_addr == pc_q) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d    = dec_addr;
            state_d = run ? S_FETCH : S_IDLE;
          end
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d      = pc_q + 4'd1;
        retired_d = retired_q + CNT_W'(1);
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control outputs for the state being entered; the EXEC controls are
  // taken from the decoder during DECODE and simply held through WB.
  always_comb begin
    imem_req_d    = (state_d == S_FETCH);
    alu_en_d      = 1'b0;
    alu_op_d      = 2'b00;
    alu_sel_imm_d = 1'b0;
    rf_we_d       = 1'b0;
    case (state_d)
      S_EXEC: begin
        if (dec_opcode != OP_JMP) begin
          alu_en_d      = 1'b1;
          alu_op_d      = dec_opcode;
          alu_sel_imm_d = (dec_opcode == OP_LI);
        end
      end
      S_WB: begin
        alu_en_d      = alu_en_q;
        alu_op_d      = alu_op_q;
        alu_sel_imm_d = alu_sel_imm_q;
        rf_we_d       = 1'b1;
      end
      default: begin
        alu_en_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears strobes asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= 8'h00;
      retired_q     <= '0;
      halted_q      <= 1'b0;
      imem_req_q    <= 1'b0;
      alu_en_q      <= 1'b0;
      alu_op_q      <= 2'b00;
      alu_sel_imm_q <= 1'b0;
      rf_we_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      retired_q     <= retired_d;
      halted_q      <= halted_d;
      imem_req_q    <= imem_req_d;
      alu_en_q      <= alu_en_d;
      alu_op_q      <= alu_op_d;
      alu_sel_imm_q <= alu_sel_imm_d;
      rf_we_q       <= rf_we_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign ir          = ir_q;
  assign alu_en      = alu_en_q;
  assign alu_op      = alu_op_q;
  assign alu_sel_imm = alu_sel_imm_q;
  assign rf_we       = rf_we_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_scpu_ctrl.sv
// Bench for scpu_ctrl: an imem responder with programmable ack delay (and
// stray acks outside FETCH), a decoder model on ir, expected per-instruction
// records queued by the stimulus and checked by a monitor at each retirement.
module tb_scpu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic [7:0] imem_rdata = 8'h00;
  logic       imem_ack = 1'b0;
  logic [7:0] ir;
  logic [1:0] dec_opcode;
  logic [3:0] dec_addr;
  logic       alu_en;
  logic [1:0] alu_op;
  logic       alu_sel_imm;
  logic       rf_we;
  logic [3:0] pc;
  logic [2:0] state;
  logic       halted;
  logic [7:0] retired;

  scpu_ctrl #(.RESET_PC(4'h0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .ir(ir), .dec_opcode(dec_opcode), .dec_addr(dec_addr),
    .alu_en(alu_en), .alu_op(alu_op), .alu_sel_imm(alu_sel_imm), .rf_we(rf_we),
    .pc(pc), .state(state), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  assign dec_opcode = ir[7:6];
  assign dec_addr   = ir[5:2];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // imem model
  logic [7:0] mem [16];
  int ack_delay = 0;
  int wcnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (wcnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        wcnt       = 0;
        imem_ack   = 1'b1;
        imem_rdata = 8'hFF;
      end
    end
  end

  // scoreboard
  typedef struct {
    logic [3:0] pc;
    logic [7:0] ret;
    int         we;
    int         alu;
    logic [1:0] op;
    logic       sel;
    int         lat;
    logic [3:0] fa;
  } rec_t;
  rec_t q_exp[$];

  task automatic push(input logic [3:0] p, input logic [7:0] r, input int we, input int alu,
                      input logic [1:0] op, input logic sel, input int lat, input logic [3:0] fa);
    rec_t e;
    e.pc = p; e.ret = r; e.we = we; e.alu = alu; e.op = op; e.sel = sel; e.lat = lat; e.fa = fa;
    q_exp.push_back(e);
  endtask

  logic [7:0] prev_ret = 8'h00;
  int         m_lat = 0, m_we = 0, m_alu = 0;
  logic [1:0] m_op = 2'b00;
  logic       m_sel = 1'b0;
  logic [3:0] m_fa = 4'h0;
  logic       m_fa_seen = 1'b0;
  logic       m_fa_moved = 1'b0;

  // Monitor: accumulate what each instruction did, compare on retirement.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ret = 8'h00; m_lat = 0; m_we = 0; m_alu = 0; m_op = 2'b00; m_sel = 1'b0;
        m_fa_seen = 1'b0; m_fa_moved = 1'b0;
      end else begin
        if (retired != prev_ret) begin
          if (q_exp.size() == 0) begin
            chk("sb_unexpected_retire", {24'h0, retired}, {24'h0, prev_ret});
          end else begin
            e = q_exp.pop_front();
            chk("pc_after", {28'h0, pc}, {28'h0, e.pc});
            chk("retired", {24'h0, retired}, {24'h0, e.ret});
            chk("rf_we_cycles", m_we, e.we);
            chk("alu_en_cycles", m_alu, e.alu);
            chk("alu_op", {30'h0, m_op}, {30'h0, e.op});
            chk("alu_sel_imm", {31'h0, m_sel}, {31'h0, e.sel});
            chk("latency", m_lat, e.lat);
            chk("fetch_addr", {27'h0, m_fa_moved, m_fa}, {28'h0, e.fa});
          end
          prev_ret = retired;
          m_lat = 0; m_we = 0; m_alu = 0; m_op = 2'b00; m_sel = 1'b0;
          m_fa_seen = 1'b0; m_fa_moved = 1'b0;
        end
        if (state >= 3'd1 && state <= 3'd4) m_lat++;
        if (state == 3'd1 && imem_req) begin
          if (!m_fa_seen) begin m_fa = imem_addr; m_fa_seen = 1'b1; end
          else if (imem_addr != m_fa) m_fa_moved = 1'b1;
        end
        if (rf_we) m_we++;
        if (alu_en) begin
          m_alu++;
          if (state == 3'd3) begin m_op = alu_op; m_sel = alu_sel_imm; end
        end
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin @(negedge clk); n++; end
    chk("wait_state", {29'h0, state}, {29'h0, s});
  endtask

  task automatic wait_ret(input logic [7:0] r, input int budget);
    int n = 0;
    while (retired !== r && n < budget) begin @(negedge clk); n++; end
    chk("wait_retired", {24'h0, retired}, {24'h0, r});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", {29'h0, state}, 32'h0);
    chk("rst_pc", {28'h0, pc}, 32'h0);
    chk("rst_ir", {24'h0, ir}, 32'h0);
    chk("rst_retired", {24'h0, retired}, 32'h0);
    chk("rst_strobes", {28'h0, halted, imem_req, alu_en, rf_we}, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic load_mem(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) mem[i] = fill;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    load_mem(8'h13);

    // ADD at 0, zero-wait fetch, stray acks outside FETCH
    ack_delay = 0;
    mem[0] = 8'h13;
    do_reset();
    push(4'h1, 8'd1, 1, 2, 2'b00, 1'b0, 4, 4'h0);
    run = 1'b1;
    wait_state(3'd2, 20);
    run = 1'b0;
    wait_state(3'd0, 20);
    chk("p1_ir", {24'h0, ir}, 32'h13);

    // LI at 0 with 3 wait cycles
    load_mem(8'h13);
    mem[0] = 8'hC5;
    ack_delay = 3;
    do_reset();
    push(4'h1, 8'd1, 1, 2, 2'b11, 1'b1, 7, 4'h0);
    run = 1'b1;
    wait_state(3'd2, 20);
    chk("p2_ir", {24'h0, ir}, 32'hC5);
    run = 1'b0;
    wait_state(3'd0, 20);

    // ADD, SUB, JMP 6 at pc=2, then LI at 6
    load_mem(8'h13);
    mem[0] = 8'h13; mem[1] = 8'h46; mem[2] = 8'h98; mem[6] = 8'hC5;
    ack_delay = 0;
    do_reset();
    push(4'h1, 8'd1, 1, 2, 2'b00, 1'b0, 4, 4'h0);
    push(4'h2, 8'd2, 1, 2, 2'b01, 1'b0, 4, 4'h1);
    push(4'h6, 8'd3, 0, 0, 2'b00, 1'b0, 3, 4'h2);
    push(4'h7, 8'd4, 1, 2, 2'b11, 1'b1, 4, 4'h6);
    run = 1'b1;
    wait_ret(8'd3, 40);
    wait_state(3'd2, 20);
    run = 1'b0;
    wait_state(3'd0, 20);

    // JMP-to-self at pc=4 halts; 1 wait cycle per fetch
    load_mem(8'h13);
    mem[0] = 8'h13; mem[1] = 8'hC5; mem[2] = 8'h46; mem[3] = 8'h13; mem[4] = 8'h90;
    ack_delay = 1;
    do_reset();
    push(4'h1, 8'd1, 1, 2, 2'b00, 1'b0, 5, 4'h0);
    push(4'h2, 8'd2, 1, 2, 2'b11, 1'b1, 5, 4'h1);
    push(4'h3, 8'd3, 1, 2, 2'b01, 1'b0, 5, 4'h2);
    push(4'h4, 8'd4, 1, 2, 2'b00, 1'b0, 5, 4'h3);
    push(4'h4, 8'd5, 0, 0, 2'b00, 1'b0, 4, 4'h4);
    run = 1'b1;
    wait_state(3'd5, 60);
    chk("halt_flag", {31'h0, halted}, 32'h1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      run = ~run;
      @(negedge clk);
      if (imem_req || rf_we || alu_en || state != 3'd5) cnt++;
    end
    chk("halt_quiet", cnt, 0);
    chk("halt_pc", {28'h0, pc}, 32'h4);
    do_reset();

    // JMP 15, SUB at pc=F wraps to 0; run dropped during DECODE
    load_mem(8'h13);
    mem[0] = 8'hBC; mem[15] = 8'h46;
    ack_delay = 0;
    do_reset();
    push(4'hF, 8'd1, 0, 0, 2'b00, 1'b0, 3, 4'h0);
    push(4'h0, 8'd2, 1, 2, 2'b01, 1'b0, 4, 4'hF);
    run = 1'b1;
    wait_ret(8'd1, 20);
    wait_state(3'd2, 20);
    run = 1'b0;
    wait_state(3'd0, 20);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req || state != 3'd0) cnt++;
    end
    chk("park_idle_quiet", cnt, 0);
    chk("park_pc", {28'h0, pc}, 32'h0);

    // Reset mid-FETCH with the ack withheld
    ack_delay = 1000;
    run = 1'b1;
    wait_state(3'd1, 10);
    repeat (3) @(negedge clk);
    chk("pending_req", {27'h0, imem_req, imem_addr}, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'h0, imem_req}, 32'h0);
    chk("async_rst_state", {29'h0, state}, 32'h0);
    chk("async_rst_pc", {28'h0, pc}, 32'h0);
    chk("async_rst_retired", {24'h0, retired}, 32'h0);
    chk("async_rst_we", {31'h0, rf_we}, 32'h0);
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("sb_drained", q_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
